grid_io_cfg_tile: RTL and testbench

- Parametrised IO physical tile that replaces fixed four-subtile IO grids.
- Holds NUM_SUBTILES bidirectional pad channels, each set by its own configuration bits (direction, data inversion).
- Configuration arrives on a gated scan chain (ccff_head to ccff_tail). A shadow register is updated only by a length-checked commit, so a partially shifted chain never drives the pads.
- Sits on the fabric boundary between the routing channels and the SoC pad ring.

---
 rtl/grid_io_cfg_tile_if.sv | 27 ++
 rtl/grid_io_cfg_tile.sv | 75 +++++++
 tb/tb_grid_io_cfg_tile.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/grid_io_cfg_tile_if.sv
// grid_io_cfg_tile_if: scan-chain control and pad/fabric bundle of the IO tile.
interface grid_io_cfg_tile_if #(
    parameter int NUM_SUBTILES = 4
);
    logic                    isol_n;
    logic                    ccff_head;
    logic                    ccff_en;
    logic                    cfg_commit;
    logic                    ccff_tail;
    logic                    cfg_valid;
    logic                    cfg_err;
    logic [0:NUM_SUBTILES-1] gfpga_pad_io_soc_in;
    logic [0:NUM_SUBTILES-1] gfpga_pad_io_soc_out;
    logic [0:NUM_SUBTILES-1] gfpga_pad_io_soc_dir;
    logic [0:NUM_SUBTILES-1] fabric_outpad;
    logic [0:NUM_SUBTILES-1] fabric_inpad;

    modport master (
        output isol_n, ccff_head, ccff_en, cfg_commit, gfpga_pad_io_soc_in, fabric_outpad,
        input  ccff_tail, cfg_valid, cfg_err, gfpga_pad_io_soc_out, gfpga_pad_io_soc_dir, fabric_inpad
    );

    modport slave (
        input  isol_n, ccff_head, ccff_en, cfg_commit, gfpga_pad_io_soc_in, fabric_outpad,
        output ccff_tail, cfg_valid, cfg_err, gfpga_pad_io_soc_out, gfpga_pad_io_soc_dir, fabric_inpad
    );
endinterface

// File: rtl/grid_io_cfg_tile.sv
// grid_io_cfg_tile: parametrised bidirectional IO tile whose pad config comes
// from a scan chain, copied to a shadow register only by a length-checked commit.
module grid_io_cfg_tile #(
    parameter int NUM_SUBTILES = 4
) (
    input logic               prog_clk,
    input logic               prog_reset,
    grid_io_cfg_tile_if.slave io
);
    localparam int CFG_W = 2;
    localparam int L = CFG_W * NUM_SUBTILES;
    localparam int CNT_W = $clog2(L + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(L);
    localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(L + 1);

    logic [0:L-1]            c_q, c_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [0:NUM_SUBTILES-1] sdir_q, sdir_d;
    logic [0:NUM_SUBTILES-1] sinv_q, sinv_d;
    logic                    valid_q, valid_d;
    logic                    err_q, err_d;

    always_comb begin
        c_d = c_q;
        cnt_d = cnt_q;
        sdir_d = sdir_q;
        sinv_d = sinv_q;
        valid_d = valid_q;
        err_d = err_q;
        if (io.ccff_en) begin
            c_d = {io.ccff_head, c_q[0:L-2]};
            cnt_d = (cnt_q == CNT_OVER) ? CNT_OVER : cnt_q + CNT_W'(1);
        end
        // Commit judges the pre-edge chain, so a same-cycle shift restarts the count at 1.
        if (io.cfg_commit) begin
            cnt_d = io.ccff_en ? CNT_W'(1) : '0;
            if (cnt_q == CNT_FULL) begin
                for (int k = 0; k < NUM_SUBTILES; k++) begin
                    sdir_d[k] = c_q[CFG_W*k];
                    sinv_d[k] = c_q[CFG_W*k+1];
                end
                valid_d = 1'b1;
                err_d = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge prog_clk or negedge prog_reset) begin
        if (!prog_reset) begin
            c_q <= '0;
            cnt_q <= '0;
            sdir_q <= '1;
            sinv_q <= '0;
            valid_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            c_q <= c_d;
            cnt_q <= cnt_d;
            sdir_q <= sdir_d;
            sinv_q <= sinv_d;
            valid_q <= valid_d;
            err_q <= err_d;
        end
    end

    assign io.ccff_tail = c_q[L-1];
    assign io.cfg_valid = valid_q;
    assign io.cfg_err = err_q;
    // Isolation parks every pad as an undriven input regardless of the shadow.
    assign io.gfpga_pad_io_soc_dir = sdir_q | {NUM_SUBTILES{~io.isol_n}};
    assign io.gfpga_pad_io_soc_out = {NUM_SUBTILES{io.isol_n}} & ~sdir_q & (io.fabric_outpad ^ sinv_q);
    assign io.fabric_inpad = {NUM_SUBTILES{io.isol_n}} & sdir_q & (io.gfpga_pad_io_soc_in ^ sinv_q);
endmodule

// File: tb/tb_grid_io_cfg_tile.sv
// tb_grid_io_cfg_tile: directed and randomized checks against a shift-history reference model.
module tb_grid_io_cfg_tile;
    localparam int N = 4;
    localparam int L = 2 * N;

    logic prog_clk = 1'b0;
    logic prog_reset = 1'b0;
    grid_io_cfg_tile_if #(.NUM_SUBTILES(N)) io ();
    grid_io_cfg_tile #(.NUM_SUBTILES(N)) dut (.prog_clk(prog_clk), .prog_reset(prog_reset), .io(io.slave));

    always #5 prog_clk = ~prog_clk;

    int errors = 0;
    int checks = 0;
    bit hist[$];
    int m_cnt;
    bit m_dir[N];
    bit m_inv[N];
    bit m_valid;
    bit m_err;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bit shifted in i shifts ago (0 = most recent); zero if nothing that old since reset.
    function automatic bit at(int i);
        return i < hist.size() ? hist[i] : 1'b0;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_cnt = 0;
        for (int k = 0; k < N; k++) begin
            m_dir[k] = 1'b1;
            m_inv[k] = 1'b0;
        end
        m_valid = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic model_step(bit en, bit head, bit commit);
        if (commit) begin
            if (m_cnt == L) begin
                for (int k = 0; k < N; k++) begin
                    m_dir[k] = at(2 * k);
                    m_inv[k] = at(2 * k + 1);
                end
                m_valid = 1'b1;
                m_err = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end
        if (en) begin
            hist.push_front(head);
            if (hist.size() > L) void'(hist.pop_back());
        end
        if (commit) m_cnt = en ? 1 : 0;
        else if (en && m_cnt < L + 1) m_cnt++;
    endtask

    task automatic check_all(string tag);
        logic [0:N-1] ed, eo, ei;
        for (int k = 0; k < N; k++) begin
            if (!io.isol_n) begin
                ed[k] = 1'b1; eo[k] = 1'b0; ei[k] = 1'b0;
            end else if (m_dir[k]) begin
                ed[k] = 1'b1; eo[k] = 1'b0; ei[k] = io.gfpga_pad_io_soc_in[k] ^ m_inv[k];
            end else begin
                ed[k] = 1'b0; eo[k] = io.fabric_outpad[k] ^ m_inv[k]; ei[k] = 1'b0;
            end
        end
        check({tag, ".tail"}, io.ccff_tail, at(L - 1));
        check({tag, ".valid"}, io.cfg_valid, m_valid);
        check({tag, ".err"}, io.cfg_err, m_err);
        check({tag, ".dir"}, io.gfpga_pad_io_soc_dir, ed);
        check({tag, ".out"}, io.gfpga_pad_io_soc_out, eo);
        check({tag, ".inpad"}, io.fabric_inpad, ei);
    endtask

    task automatic cyc(bit en, bit head, bit commit, string tag);
        io.ccff_en = en;
        io.ccff_head = head;
        io.cfg_commit = commit;
        @(posedge prog_clk);
        model_step(en, head, commit);
        #1;
        io.ccff_en = 1'b0;
        io.cfg_commit = 1'b0;
        check_all(tag);
    endtask

    // Shift n bits, most significant of the n first.
    task automatic shift_bits(logic [15:0] bits, int n, string tag);
        for (int i = n - 1; i >= 0; i--) cyc(1'b1, bits[i], 1'b0, tag);
    endtask

    task automatic shift_rand(int n, string tag);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'($urandom), 1'b0, tag);
    endtask

    task automatic async_reset(string tag);
        io.ccff_en = 1'b1;
        io.ccff_head = 1'b1;
        @(posedge prog_clk);
        #3;
        prog_reset = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        io.ccff_en = 1'b0;
        @(negedge prog_clk);
        prog_reset = 1'b1;
        #1;
        check_all({tag, "_rel"});
    endtask

    initial begin
        bit exp_tail;
        io.isol_n = 1'b1;
        io.ccff_head = 1'b0;
        io.ccff_en = 1'b0;
        io.cfg_commit = 1'b0;
        io.gfpga_pad_io_soc_in = '0;
        io.fabric_outpad = '0;
        model_reset();
        #12;
        check_all("reset");
        check("reset.dir_all", io.gfpga_pad_io_soc_dir, 4'b1111);
        @(negedge prog_clk);
        prog_reset = 1'b1;

        shift_bits(16'b101, 3, "pre");
        async_reset("midshift_rst");
        check("midshift.tail", io.ccff_tail, 1'b0);
        repeat (10) cyc(1'b0, 1'b1, 1'b0, "idle");

        shift_bits(16'b01010100, 8, "load");
        cyc(1'b0, 1'b0, 1'b1, "commit_full");
        check("full.valid", io.cfg_valid, 1'b1);
        check("full.dir", io.gfpga_pad_io_soc_dir, 4'b0111);
        io.fabric_outpad = 4'b1000;
        io.gfpga_pad_io_soc_in = 4'b0010;
        #1;
        check("full.out0", io.gfpga_pad_io_soc_out[0], 1'b1);
        check("full.inpad2", io.fabric_inpad[2], 1'b1);
        check_all("full_pads");

        shift_rand(7, "short");
        cyc(1'b0, 1'b0, 1'b1, "commit_short");
        check("short.err", io.cfg_err, 1'b1);
        check("short.dir", io.gfpga_pad_io_soc_dir, 4'b0111);
        shift_rand(9, "long");
        cyc(1'b0, 1'b0, 1'b1, "commit_long");
        check("long.err", io.cfg_err, 1'b1);
        shift_rand(8, "exact");
        cyc(1'b0, 1'b0, 1'b1, "commit_exact");
        check("exact.err", io.cfg_err, 1'b0);

        shift_bits(16'b01011110, 8, "inv_load");
        cyc(1'b0, 1'b0, 1'b1, "commit_inv");
        io.gfpga_pad_io_soc_in = 4'b0000;
        io.fabric_outpad = 4'b0000;
        #1;
        check("inv.inpad1", io.fabric_inpad[1], 1'b1);
        check("inv.out0", io.gfpga_pad_io_soc_out[0], 1'b1);
        check_all("inv_pads");

        shift_rand(8, "simul_load");
        exp_tail = at(6);
        cyc(1'b1, 1'($urandom), 1'b1, "commit_simul");
        check("simul.tail", io.ccff_tail, exp_tail);
        check("simul.err", io.cfg_err, 1'b0);
        shift_rand(7, "simul_rest");
        cyc(1'b0, 1'b0, 1'b1, "commit_cnt1");
        check("cnt1.err", io.cfg_err, 1'b0);

        shift_bits(16'b01010100, 8, "iso_load");
        cyc(1'b0, 1'b0, 1'b1, "commit_iso");
        io.isol_n = 1'b0;
        io.fabric_outpad = 4'b1111;
        io.gfpga_pad_io_soc_in = 4'b1111;
        #1;
        check("iso.dir", io.gfpga_pad_io_soc_dir, 4'b1111);
        check("iso.out", io.gfpga_pad_io_soc_out, 4'b0000);
        check("iso.inpad", io.fabric_inpad, 4'b0000);
        for (int i = 0; i < L; i++) begin
            exp_tail = at(L - 2);
            cyc(1'b1, 1'($urandom), 1'b0, "iso_shift");
            check("iso.passthru", io.ccff_tail, exp_tail);
        end
        cyc(1'b0, 1'b0, 1'b1, "commit_isolated");
        io.isol_n = 1'b1;

        for (int r = 0; r < 60; r++) begin
            int n;
            case ($urandom_range(0, 5))
                0: n = 7;
                1: n = 9;
                2: n = $urandom_range(0, 12);
                default: n = 8;
            endcase
            for (int i = 0; i < n; i++) begin
                io.isol_n = ($urandom_range(0, 7) != 0);
                io.gfpga_pad_io_soc_in = 4'($urandom);
                io.fabric_outpad = 4'($urandom);
                if ($urandom_range(0, 4) == 0) cyc(1'b0, 1'($urandom), 1'b0, "rnd_idle");
                cyc(1'b1, 1'($urandom), 1'b0, "rnd_shift");
            end
            cyc(1'($urandom), 1'($urandom), 1'b1, "rnd_commit");
            if (r % 20 == 19) async_reset("rnd_rst");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
